// File: rtl/data_mem_tlul_host_pkg.sv
// Shared FSM states, size encodings and byte-enable decode for the TL-UL data host.
package data_mem_tlul_host_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AREQ  = 2'd1,
        DWAIT = 2'd2,
        LERR  = 2'd3
    } host_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [1:0] size;
        logic [1:0] offset;
        logic       legal;
    } be_decode_t;

    // Anything that is not a single byte or an aligned half goes out as a full word.
    function automatic be_decode_t decode_be(input logic [3:0] be);
        be_decode_t d;
        d.legal  = |be;
        d.size   = SIZE_WORD;
        d.offset = 2'b00;
        case (be)
            4'h1: begin d.size = SIZE_BYTE; d.offset = 2'd0; end
            4'h2: begin d.size = SIZE_BYTE; d.offset = 2'd1; end
            4'h4: begin d.size = SIZE_BYTE; d.offset = 2'd2; end
            4'h8: begin d.size = SIZE_BYTE; d.offset = 2'd3; end
            4'h3: begin d.size = SIZE_HALF; d.offset = 2'd0; end
            4'hC: begin d.size = SIZE_HALF; d.offset = 2'd2; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types and opcode encodings used by the data-side host adapter.
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    localparam logic [13:0] TL_A_USER_DEFAULT = 14'h0;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [13:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/data_mem_tlul_be_decode.sv
// Combinational byte-enable decoder: TL-UL size, address low bits and legality.
module data_mem_tlul_be_decode
    import data_mem_tlul_host_pkg::*;
(
    input  logic [3:0] be,
    output logic [1:0] size,
    output logic [1:0] offset,
    output logic       legal
);

    be_decode_t dec;

    always_comb begin
        dec    = decode_be(be);
        size   = dec.size;
        offset = dec.offset;
        legal  = dec.legal;
    end

endmodule

// File: rtl/data_mem_tlul_host.sv
// Core data port to TL-UL host adapter, one transaction in flight, A channel fully registered.
// Optional error address capture enabled by DATA_MEM_TLUL_HOST_ERR_CAPTURE_EN.
module data_mem_tlul_host
    import data_mem_tlul_host_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int SourceId  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [AddrWidth-1:0] data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    output logic                 data_rvalid_o,
    output logic [DataWidth-1:0] data_rdata_o,
    output logic                 data_err_o,
    output tlul_pkg::tl_h2d_t    tl_h_o,
    input  tlul_pkg::tl_d2h_t    tl_h_i
`ifdef DATA_MEM_TLUL_HOST_ERR_CAPTURE_EN
    ,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic                 err_valid_o,
    input  logic                 err_clr_i
`endif
);

    localparam logic [7:0] SrcId = 8'(SourceId);

    host_state_e          state_q;
    logic                 a_valid_q;
    logic                 d_ready_q;
    logic                 we_q;
    logic [3:0]           be_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [2:0]           opcode_q;
    logic [1:0]           size_q;
    logic [31:0]          a_address_q;
    logic                 rvalid_q;
    logic                 err_q;
    logic [DataWidth-1:0] rdata_q;

    logic [1:0]  dec_size;
    logic [1:0]  dec_offset;
    logic        dec_legal;
    logic [2:0]  req_opcode;
    logic [31:0] req_address;
    logic [2:0]  exp_d_opcode;
    logic        rsp_err;

    data_mem_tlul_be_decode u_be_decode (
        .be     (data_be_i),
        .size   (dec_size),
        .offset (dec_offset),
        .legal  (dec_legal)
    );

    // The rvalid cycle is held off so a new request never overlaps a completion.
    assign data_gnt_o = (state_q == IDLE) && data_req_i && !rvalid_q;

    always_comb begin
        req_opcode = tlul_pkg::Get;
        if (data_we_i) begin
            req_opcode = (data_be_i == 4'hF) ? tlul_pkg::PutFullData : tlul_pkg::PutPartialData;
        end
        req_address = 32'({data_addr_i[AddrWidth-1:2], dec_offset});
    end

    always_comb begin
        exp_d_opcode = we_q ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData;
        rsp_err      = tl_h_i.d_error
                     | (tl_h_i.d_opcode != exp_d_opcode)
                     | (tl_h_i.d_source != SrcId);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            a_valid_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            opcode_q    <= '0;
            size_q      <= '0;
            a_address_q <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (data_gnt_o) begin
                        we_q        <= data_we_i;
                        be_q        <= data_be_i;
                        addr_q      <= data_addr_i;
                        wdata_q     <= data_wdata_i;
                        opcode_q    <= req_opcode;
                        size_q      <= dec_size;
                        a_address_q <= req_address;
                        if (dec_legal) begin
                            a_valid_q <= 1'b1;
                            state_q   <= AREQ;
                        end else begin
                            state_q   <= LERR;
                        end
                    end
                end
                AREQ: begin
                    if (tl_h_i.a_ready) begin
                        a_valid_q <= 1'b0;
                        d_ready_q <= 1'b1;
                        state_q   <= DWAIT;
                    end
                end
                DWAIT: begin
                    if (tl_h_i.d_valid) begin
                        d_ready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        err_q     <= rsp_err;
                        rdata_q   <= (!we_q && !rsp_err) ? tl_h_i.d_data : '0;
                        state_q   <= IDLE;
                    end
                end
                LERR: begin
                    rvalid_q <= 1'b1;
                    err_q    <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        tl_h_o           = '0;
        tl_h_o.a_valid   = a_valid_q;
        tl_h_o.a_opcode  = opcode_q;
        tl_h_o.a_param   = 3'h0;
        tl_h_o.a_size    = size_q;
        tl_h_o.a_source  = SrcId;
        tl_h_o.a_address = a_address_q;
        tl_h_o.a_mask    = be_q;
        tl_h_o.a_data    = wdata_q;
        tl_h_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
        tl_h_o.d_ready   = d_ready_q;
    end

    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = rdata_q;

`ifdef DATA_MEM_TLUL_HOST_ERR_CAPTURE_EN
    logic                 err_event;
    logic                 err_valid_q;
    logic [AddrWidth-1:0] err_addr_q;

    assign err_event = ((state_q == DWAIT) && tl_h_i.d_valid && rsp_err) || (state_q == LERR);

    // A fresh error beats a simultaneous clear so it is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (err_event && (!err_valid_q || err_clr_i)) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= addr_q;
        end else if (err_clr_i) begin
            err_valid_q <= 1'b0;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
`endif

endmodule
